// File: rtl/brs_uart_rx.sv
// brs_uart_rx: UART receive front-end (8N1) feeding the BRS core through a one-deep valid/ready register.
// Define BRS_RX_PARITY_EN to receive 8E1 frames and report even-parity mismatches on parity_err.
module brs_uart_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef BRS_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;
`endif

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             rx_meta;
    logic             rx_s;
    logic             bit_done;
    logic             par_bad;

    // NOTE: the synchroniser resets to 1 so an idle line is not mistaken for a start bit after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    assign bit_done = (cnt == BIT_LAST);

`ifdef BRS_RX_PARITY_EN
    logic par_bit;
    assign par_bad = ^{shift, par_bit};
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef BRS_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef BRS_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // NOTE: a load in the STOP branch below is a later non-blocking write and wins over this clear.
            if (m_valid && m_ready) m_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef BRS_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`ifdef BRS_RX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            // A parity failure drops the byte without touching the holding register.
                            if (par_bad) begin
`ifdef BRS_RX_PARITY_EN
                                parity_err <= 1'b1;
`endif
                            end else if (!m_valid || m_ready) begin
                                m_data  <= shift;
                                m_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
